// File: rtl/fetch_pkg.sv
// fetch_pkg: shared defaults, queue entry layout and FSM state encoding for the fetch queue.
package fetch_pkg;
  localparam int FQ_DEPTH = 4;
  localparam logic [63:0] FQ_RESET_PC = 64'h0;
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } fq_entry_t;
  typedef enum logic {BOOT, RUN} fq_state_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: circular instruction buffer with push, pop, flush-clear and occupancy count.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     clear_i,
  input  logic [63:0]              pc_i,
  input  logic [31:0]              inst_i,
  output logic [63:0]              pc_o,
  output logic [31:0]              inst_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  fq_entry_t mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  always_comb begin
    head_d  = clear_i ? tail_q : head_q + AW'(pop_i);
    tail_d  = (push_i && !clear_i) ? tail_q + AW'(1) : tail_q;
    count_d = clear_i ? '0 : count_q + CW'(push_i) - CW'(pop_i);
  end
  // Storage is reset so the head outputs read zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i && !clear_i) mem_q[tail_q] <= '{pc: pc_i, inst: inst_i};
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
  assign pc_o    = mem_q[head_q].pc;
  assign inst_o  = mem_q[head_q].inst;
  assign count_o = count_q;
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: credit-based instruction prefetcher feeding IF/ID through a small queue.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = FQ_DEPTH,
  parameter logic [63:0] RESET_PC = FQ_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_i,
  input  logic [63:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [63:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  output logic        dec_valid_o,
  input  logic        dec_ready_i,
  output logic [63:0] dec_pc_o,
  output logic [31:0] dec_inst_o
);
  localparam int CW = $clog2(DEPTH) + 1;
  fq_state_t state_q, state_d;
  logic [63:0] fpc_q, fpc_d, pend_pc_q, pend_pc_d;
  logic pend_q, pend_d, push, pop;
  logic [CW-1:0] count;
  // The in-flight request holds a slot, so a full queue never sees a push.
  always_comb begin
    imem_req_o = (state_q == RUN) && !redirect_i && ((count + CW'(pend_q)) < CW'(DEPTH));
    push       = pend_q && !redirect_i;
    pop        = dec_valid_o && dec_ready_i && !redirect_i;
    state_d    = RUN;
    fpc_d      = redirect_i ? redirect_pc_i : imem_req_o ? fpc_q + 64'd4 : fpc_q;
    pend_d     = imem_req_o;
    pend_pc_d  = imem_req_o ? fpc_q : pend_pc_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= BOOT;
      fpc_q     <= RESET_PC;
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      fpc_q     <= fpc_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
    end
  end
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .clear_i (redirect_i),
    .pc_i    (pend_pc_q),
    .inst_i  (imem_rdata_i),
    .pc_o    (dec_pc_o),
    .inst_o  (dec_inst_o),
    .count_o (count)
  );
  assign dec_valid_o = count != '0;
  assign imem_addr_o = fpc_q;
endmodule
